up_sequencer: RTL and testbench
===============================

# up_sequencer

Parametrised microcoded control sequencer for the small microprocessor datapath. It drives the ALU op, register bank, PC, SP and memory strobes. Beyond the existing fetch/decode/execute flow it adds:
- a configurable boot register-load depth
- memory wait states with timeout
- vectored interrupts with an enable flag
- HALT
- illegal-opcode trap

## Interface
- INIT_REGS, 3, number of register-bank entries loaded from memory after reset (1..7)
- WAIT_LIMIT, 15, maximum consecutive mem_rdy-low cycles tolerated in one data state (1..255)
- IR_W, 4, instruction-register width (>=4); only ir[3:0] is decoded, and any nonzero ir[IR_W-1:4] is illegal
- clk  input  1  clock, rising edge
- nRst  input  1  reset, asynchronous, active-low
- int  input  1  interrupt request, level
- ir  input  IR_W  current instruction opcode
- z  input  1  ALU zero flag
- mem_rdy  input  1  memory data valid for the current data state
- op  output  5  datapath operation select
- ir_we, pc_we, rb_we, sp_we, mem_we, ale  output  1 each  datapath strobes
- rb_sel  output  3  register-bank select
- int_ack  output  1  one-cycle interrupt acknowledge
- halted  output  1  high while in HALT
- bus_err  output  1  sticky memory timeout flag

## Operation
- All strobes are combinational from state, ir, z and the stall condition.
- Default values: op=00000, rb_sel=100, all strobes 0.
- Registered state: state, load_cnt[2:0], wait_cnt[7:0], ie, bus_err.

States and outputs:
- LOAD0: op=10000, ale.
- LOADk (k=1..INIT_REGS): rb_sel=k-1, rb_we. If k<INIT_REGS, also op=10001 and ale.
  - After the last LOADk, go to FETCH.
- FETCH: op=10100, ale.
- DECODE: op=10101, ir_we, pc_we.
- EX1/EX2/EX3, decoded on ir[3:0]:
  - 0..3: EX1 op={0,ir}, rb_we. Then to FETCH.
  - 4..6: op={0,ir} in all three cycles, rb_we in all three. With b=100+(ir-4), rb_sel is b in EX1, b+1 in EX2, b in EX3. Then to FETCH.
  - 7: EX1; if z then op=10110 and pc_we. Then to FETCH.
  - 8 (call): EX1 op=10111, sp_we, mem_we, ale. EX2 op=11000, pc_we. Then to FETCH.
  - 9: EX1 op=11001, ale. EX2 no strobes. Then to FETCH.
  - A: ie<=1. B: ie<=0. Both single EX1, then to FETCH.
  - C: to HALT.
  - D..F or nonzero high bits: illegal; go to TRAP1.
- INT1/TRAP1: op=10111, sp_we, mem_we, ale. int_ack=1 in INT1 only.
- INT2/TRAP2: pc_we. op=11010 (vector 0) in INT2, op=11011 (vector 1) in TRAP2. ie<=0. Then to FETCH.
- HALT: halted=1, no strobes.
  - int=1 and ie=1: go to INT1.
  - int=1 and ie=0: go to FETCH.
  - int=0: stay.
- Interrupt check: every transition that would enter FETCH (from an EX state or INT2/TRAP2) goes to INT1 instead when int&ie. Boot (LOADk→FETCH) never diverts.
- Wait states:
  - Data states are LOADk, DECODE, EX2 of op 8, and EX2 of op 9.
  - While a data state sees mem_rdy=0: state holds, all *_we are forced 0 (op, ale and rb_sel still driven), and wait_cnt increments.
  - wait_cnt clears on every state change.
  - If wait_cnt reaches WAIT_LIMIT while mem_rdy=0: bus_err<=1 and go to HALT. bus_err clears only on reset.
  - From a HALT entered this way, int with ie=0 still resumes FETCH.
- Simultaneous events: bus timeout wins over interrupt. Illegal-opcode decode wins over a pending interrupt.

## Timing
- Reset (async): state=LOAD0, load_cnt=1, wait_cnt=0, ie=0, bus_err=0.
  - Outputs during reset: op=10000, ale=1, everything else 0, rb_sel=100.
  - Reset mid-instruction aborts immediately with no further strobes.
- Boot latency with zero waits: INIT_REGS+1 cycles from reset release to FETCH.
- Instruction length with zero waits, including FETCH and DECODE:
  - ops 0-3, 7, A, B: 3 cycles
  - ops 8, 9: 4 cycles
  - ops 4-6: 5 cycles
- Interrupt entry adds 2 cycles (INT1, INT2) before the next FETCH. int is sampled in the final EX cycle.
- Each mem_rdy-low cycle adds exactly one cycle.

## Test plan
- Boot, INIT_REGS=3, mem_rdy=1: LOAD0 then rb_we with rb_sel 000, 001, 010 on cycles 1-3. FETCH (op=10100) on cycle 4.
- ir=5, mem_rdy=1: EX1/EX2/EX3 give rb_sel 101, 110, 101 with op=00101 and rb_we each cycle. Next state FETCH.
- ir=A, then int=1 during the following ir=0 execute: after EX1, INT1 with int_ack=1, sp_we=1, mem_we=1; INT2 with op=11010, pc_we=1; then FETCH with ie=0.
- mem_rdy=0 for 2 cycles in DECODE: ir_we/pc_we stay 0 for 2 cycles, then assert one cycle. Total instruction length +2.
- WAIT_LIMIT=4, mem_rdy stuck 0 in DECODE: bus_err rises after 4 stall cycles, halted=1. int=1 with ie=0 resumes FETCH; bus_err stays 1.
- ir=E: TRAP1 (sp_we, mem_we, ale), TRAP2 (op=11011, pc_we), FETCH. ir=C: halted=1 until int.

Source files
------------

// File: rtl/up_sequencer_if.sv
// Datapath-side signal bundle of the microcoded sequencer.
// The interrupt request is named int_req because "int" is a reserved word in SystemVerilog.
interface up_sequencer_if #(
  parameter int unsigned IR_W = 4
);
  logic            int_req;
  logic [IR_W-1:0] ir;
  logic            z;
  logic            mem_rdy;
  logic [4:0]      op;
  logic            ir_we;
  logic            pc_we;
  logic            rb_we;
  logic            sp_we;
  logic            mem_we;
  logic            ale;
  logic [2:0]      rb_sel;
  logic            int_ack;
  logic            halted;
  logic            bus_err;

  modport master (
    input  int_req, ir, z, mem_rdy,
    output op, ir_we, pc_we, rb_we, sp_we, mem_we, ale, rb_sel, int_ack, halted, bus_err
  );

  modport slave (
    output int_req, ir, z, mem_rdy,
    input  op, ir_we, pc_we, rb_we, sp_we, mem_we, ale, rb_sel, int_ack, halted, bus_err
  );
endinterface

// File: rtl/up_sequencer.sv
// Microcoded control sequencer: boot register load, fetch/decode/execute, vectored
// interrupts, illegal-opcode trap, HALT and memory wait states with a timeout.
module up_sequencer #(
  parameter int unsigned INIT_REGS  = 3,
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned IR_W       = 4
) (
  input logic            clk,
  input logic            nRst,
  up_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    StLoad0, StLoad, StFetch, StDecode, StEx1, StEx2, StEx3,
    StInt1, StInt2, StTrap1, StTrap2, StHalt
  } state_e;

  state_e          state_q, state_d, nxt, to_fetch;
  logic [2:0]      load_cnt_q, load_cnt_d, load_nxt;
  logic [7:0]      wait_cnt_q, wait_cnt_d;
  logic            ie_q, ie_d, bus_err_q, bus_err_d;
  logic [IR_W-1:0] ir;
  logic [3:0]      lo;
  logic            illegal, data_st, stall;
  logic [4:0]      op;
  logic [2:0]      rb_sel;
  logic            ir_we, pc_we, rb_we, sp_we, mem_we, ale, int_ack, halted;

  assign ir       = bus.ir;
  assign lo       = ir[3:0];
  assign illegal  = ((ir >> 4) != '0) || (lo >= 4'hD);
  // Every return to FETCH from execute or a vector state is diverted by a pending interrupt.
  assign to_fetch = (bus.int_req && ie_q) ? StInt1 : StFetch;

  always_comb begin
    nxt      = state_q;
    load_nxt = load_cnt_q;
    ie_d     = ie_q;
    data_st  = 1'b0;
    stall    = 1'b0;
    op       = 5'b00000;
    rb_sel   = 3'b100;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    rb_we    = 1'b0;
    sp_we    = 1'b0;
    mem_we   = 1'b0;
    ale      = 1'b0;
    int_ack  = 1'b0;
    halted   = 1'b0;

    unique case (state_q)
      StLoad0: begin
        op  = 5'b10000;
        ale = 1'b1;
        nxt = StLoad;
      end
      StLoad: begin
        data_st = 1'b1;
        rb_sel  = load_cnt_q - 3'd1;
        rb_we   = 1'b1;
        if (32'(load_cnt_q) < INIT_REGS) begin
          op       = 5'b10001;
          ale      = 1'b1;
          load_nxt = load_cnt_q + 3'd1;
        end else begin
          nxt = StFetch;
        end
      end
      StFetch: begin
        op  = 5'b10100;
        ale = 1'b1;
        nxt = StDecode;
      end
      StDecode: begin
        data_st = 1'b1;
        op      = 5'b10101;
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        nxt     = StEx1;
      end
      StEx1: begin
        if (illegal) begin
          nxt = StTrap1;
        end else begin
          case (lo)
            4'h0, 4'h1, 4'h2, 4'h3: begin
              op    = {1'b0, lo};
              rb_we = 1'b1;
              nxt   = to_fetch;
            end
            4'h4, 4'h5, 4'h6: begin
              op     = {1'b0, lo};
              rb_we  = 1'b1;
              rb_sel = lo[2:0];
              nxt    = StEx2;
            end
            4'h7: begin
              op    = bus.z ? 5'b10110 : 5'b00000;
              pc_we = bus.z;
              nxt   = to_fetch;
            end
            4'h8: begin
              op     = 5'b10111;
              sp_we  = 1'b1;
              mem_we = 1'b1;
              ale    = 1'b1;
              nxt    = StEx2;
            end
            4'h9: begin
              op  = 5'b11001;
              ale = 1'b1;
              nxt = StEx2;
            end
            4'hA: begin
              ie_d = 1'b1;
              nxt  = to_fetch;
            end
            4'hB: begin
              ie_d = 1'b0;
              nxt  = to_fetch;
            end
            4'hC:    nxt = StHalt;
            default: nxt = StTrap1;
          endcase
        end
      end
      StEx2: begin
        case (lo)
          4'h4, 4'h5, 4'h6: begin
            op     = {1'b0, lo};
            rb_we  = 1'b1;
            rb_sel = lo[2:0] + 3'd1;
            nxt    = StEx3;
          end
          4'h8: begin
            data_st = 1'b1;
            op      = 5'b11000;
            pc_we   = 1'b1;
            nxt     = to_fetch;
          end
          4'h9: begin
            data_st = 1'b1;
            nxt     = to_fetch;
          end
          default: nxt = to_fetch;
        endcase
      end
      StEx3: begin
        op     = {1'b0, lo};
        rb_we  = 1'b1;
        rb_sel = lo[2:0];
        nxt    = to_fetch;
      end
      StInt1, StTrap1: begin
        op      = 5'b10111;
        sp_we   = 1'b1;
        mem_we  = 1'b1;
        ale     = 1'b1;
        int_ack = (state_q == StInt1);
        nxt     = (state_q == StInt1) ? StInt2 : StTrap2;
      end
      StInt2, StTrap2: begin
        op    = (state_q == StInt2) ? 5'b11010 : 5'b11011;
        pc_we = 1'b1;
        ie_d  = 1'b0;
        nxt   = to_fetch;
      end
      StHalt: begin
        halted = 1'b1;
        if (bus.int_req) nxt = ie_q ? StInt1 : StFetch;
      end
      default: nxt = StLoad0;
    endcase

    // A data state waiting on memory holds and suppresses every write strobe.
    stall = data_st && !bus.mem_rdy;
    if (stall) begin
      ir_we  = 1'b0;
      pc_we  = 1'b0;
      rb_we  = 1'b0;
      sp_we  = 1'b0;
      mem_we = 1'b0;
    end

    state_d    = nxt;
    load_cnt_d = load_nxt;
    wait_cnt_d = '0;
    bus_err_d  = bus_err_q;
    if (stall) begin
      state_d    = state_q;
      load_cnt_d = load_cnt_q;
      wait_cnt_d = wait_cnt_q + 8'd1;
      if (32'(wait_cnt_q) + 32'd1 >= WAIT_LIMIT) begin
        bus_err_d  = 1'b1;
        state_d    = StHalt;
        wait_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= StLoad0;
      load_cnt_q <= 3'd1;
      wait_cnt_q <= '0;
      ie_q       <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      ie_q       <= ie_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign bus.op      = op;
  assign bus.rb_sel  = rb_sel;
  assign bus.ir_we   = ir_we;
  assign bus.pc_we   = pc_we;
  assign bus.rb_we   = rb_we;
  assign bus.sp_we   = sp_we;
  assign bus.mem_we  = mem_we;
  assign bus.ale     = ale;
  assign bus.int_ack = int_ack;
  assign bus.halted  = halted;
  assign bus.bus_err = bus_err_q;

endmodule

// File: tb/tb_up_sequencer.sv
// Self-checking bench: an instruction-level model emits the expected per-cycle outputs
// for randomised instructions, wait states and interrupts.
module tb_up_sequencer;

  localparam int INIT = 3;
  localparam int WL   = 4;
  localparam int IRW  = 6;

  localparam logic [4:0] WE_IR  = 5'b10000;
  localparam logic [4:0] WE_PC  = 5'b01000;
  localparam logic [4:0] WE_RB  = 5'b00100;
  localparam logic [4:0] WE_SP  = 5'b00010;
  localparam logic [4:0] WE_MEM = 5'b00001;
  localparam logic [16:0] RST_VEC = {5'b10000, 3'b100, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic nRst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [IRW-1:0] c_ir;
  logic           c_z;
  bit             ie_m;
  bit             bus_err_m;
  bit             rand_en;
  logic [IRW-1:0] irv;

  up_sequencer_if #(.IR_W(IRW)) bus ();

  up_sequencer #(
    .INIT_REGS (INIT),
    .WAIT_LIMIT(WL),
    .IR_W      (IRW)
  ) dut (
    .clk (clk),
    .nRst(nRst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] outs();
    return {bus.op, bus.rb_sel, bus.ir_we, bus.pc_we, bus.rb_we, bus.sp_we, bus.mem_we,
            bus.ale, bus.int_ack, bus.halted, bus.bus_err};
  endfunction

  function automatic bit rint();
    return rand_en && ($urandom_range(0, 3) == 0);
  endfunction

  function automatic int rand_waits();
    if ($urandom_range(0, 11) == 0) return WL + int'($urandom_range(0, 1));
    return int'($urandom_range(0, 3));
  endfunction

  // One clock cycle: drive inputs, compare all outputs mid-cycle, advance to just past the edge.
  task automatic emit(input string tag, input bit iv, input bit rdy, input logic [4:0] op,
                      input logic [2:0] rs, input logic [4:0] we, input bit al,
                      input bit ack, input bit hlt);
    bus.int_req = iv;
    bus.mem_rdy = rdy;
    bus.z       = c_z;
    bus.ir      = c_ir;
    @(negedge clk);
    check(tag, {15'd0, outs()}, {15'd0, op, rs, we, al, ack, hlt, bus_err_m});
    @(posedge clk);
    #1;
  endtask

  task automatic data_cycle(input string tag, input logic [4:0] op, input logic [2:0] rs,
                            input logic [4:0] we, input bit al, input int waits,
                            input bit fin_int, output bit tmo);
    tmo = 1'b0;
    for (int i = 0; i < waits && !tmo; i++) begin
      emit({tag, "_wait"}, rint(), 1'b0, op, rs, 5'b0, al, 1'b0, 1'b0);
      if (i + 1 >= WL) tmo = 1'b1;
    end
    if (tmo) bus_err_m = 1'b1;
    else emit(tag, fin_int, 1'b1, op, rs, we, al, 1'b0, 1'b0);
  endtask

  task automatic do_int();
    bit again;
    bit dv;
    do begin
      emit("int1", rint(), 1'b1, 5'b10111, 3'b100, WE_SP | WE_MEM, 1'b1, 1'b1, 1'b0);
      again = rint();
      emit("int2", again, 1'b1, 5'b11010, 3'b100, WE_PC, 1'b0, 1'b0, 1'b0);
      dv   = again && ie_m;
      ie_m = 1'b0;
    end while (dv);
  endtask

  task automatic do_halt();
    int n;
    n = int'($urandom_range(0, 3));
    for (int i = 0; i < n; i++)
      emit("halt", 1'b0, 1'($urandom), 5'b0, 3'b100, 5'b0, 1'b0, 1'b0, 1'b1);
    emit("halt_wake", 1'b1, 1'($urandom), 5'b0, 3'b100, 5'b0, 1'b0, 1'b0, 1'b1);
    if (ie_m) do_int();
  endtask

  task automatic do_boot(input bit rnd_waits);
    bit tmo;
    int w;
    emit("load0", rint(), 1'b1, 5'b10000, 3'b100, 5'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= INIT; k++) begin
      w = rnd_waits ? rand_waits() : 0;
      data_cycle("load", (k < INIT) ? 5'b10001 : 5'b00000, 3'(k - 1), WE_RB, k < INIT, w,
                 rint(), tmo);
      if (tmo) begin
        do_halt();
        return;
      end
    end
  endtask

  task automatic do_reset();
    nRst = 1'b0;
    #1;
    check("rst_async", {15'd0, outs()}, {15'd0, RST_VEC});
    @(posedge clk);
    #1;
    check("rst_hold", {15'd0, outs()}, {15'd0, RST_VEC});
    nRst      = 1'b1;
    ie_m      = 1'b0;
    bus_err_m = 1'b0;
  endtask

  // Starts in FETCH and returns with the next cycle expected to be FETCH again.
  task automatic do_instr(input logic [IRW-1:0] ir, input int dw, input int ew, input bit r);
    bit         tmo;
    bit         dv;
    logic [3:0] lo;
    logic [4:0] opx;
    c_ir = ir;
    c_z  = 1'($urandom);
    lo   = ir[3:0];
    opx  = {1'b0, lo};
    emit("fetch", rint(), 1'b1, 5'b10100, 3'b100, 5'b0, 1'b1, 1'b0, 1'b0);
    data_cycle("decode", 5'b10101, 3'b100, WE_IR | WE_PC, 1'b0, dw, rint(), tmo);
    if (tmo) begin
      do_halt();
      return;
    end
    if (ir[IRW-1:4] != '0 || lo >= 4'hD) begin
      emit("ex1_ill", rint(), 1'b1, 5'b0, 3'b100, 5'b0, 1'b0, 1'b0, 1'b0);
      emit("trap1", rint(), 1'b1, 5'b10111, 3'b100, WE_SP | WE_MEM, 1'b1, 1'b0, 1'b0);
      emit("trap2", r, 1'b1, 5'b11011, 3'b100, WE_PC, 1'b0, 1'b0, 1'b0);
      dv   = r && ie_m;
      ie_m = 1'b0;
      if (dv) do_int();
      return;
    end
    if (lo == 4'hC) begin
      emit("ex1_halt", rint(), 1'b1, 5'b0, 3'b100, 5'b0, 1'b0, 1'b0, 1'b0);
      do_halt();
      return;
    end
    if (lo == 4'hA || lo == 4'hB) begin
      emit("ex1_ie", r, 1'b1, 5'b0, 3'b100, 5'b0, 1'b0, 1'b0, 1'b0);
      dv   = r && ie_m;
      ie_m = (lo == 4'hA);
      if (dv) do_int();
      return;
    end
    if (lo <= 4'h3) begin
      emit("ex1_alu", r, 1'b1, opx, 3'b100, WE_RB, 1'b0, 1'b0, 1'b0);
    end else if (lo <= 4'h6) begin
      emit("ex1_rr", rint(), 1'b1, opx, lo[2:0], WE_RB, 1'b0, 1'b0, 1'b0);
      emit("ex2_rr", rint(), 1'b1, opx, lo[2:0] + 3'd1, WE_RB, 1'b0, 1'b0, 1'b0);
      emit("ex3_rr", r, 1'b1, opx, lo[2:0], WE_RB, 1'b0, 1'b0, 1'b0);
    end else if (lo == 4'h7) begin
      emit("ex1_br", r, 1'b1, c_z ? 5'b10110 : 5'b00000, 3'b100, c_z ? WE_PC : 5'b0,
           1'b0, 1'b0, 1'b0);
    end else if (lo == 4'h8) begin
      emit("ex1_call", rint(), 1'b1, 5'b10111, 3'b100, WE_SP | WE_MEM, 1'b1, 1'b0, 1'b0);
      data_cycle("ex2_call", 5'b11000, 3'b100, WE_PC, 1'b0, ew, r, tmo);
      if (tmo) begin
        do_halt();
        return;
      end
    end else begin
      emit("ex1_ld", rint(), 1'b1, 5'b11001, 3'b100, 5'b0, 1'b1, 1'b0, 1'b0);
      data_cycle("ex2_ld", 5'b00000, 3'b100, 5'b0, 1'b0, ew, r, tmo);
      if (tmo) begin
        do_halt();
        return;
      end
    end
    if (r && ie_m) do_int();
  endtask

  initial begin
    nRst        = 1'b0;
    bus.int_req = 1'b0;
    bus.mem_rdy = 1'b1;
    bus.z       = 1'b0;
    bus.ir      = '0;
    c_ir        = '0;
    c_z         = 1'b0;
    rand_en     = 1'b0;
    ie_m        = 1'b0;
    bus_err_m   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", {15'd0, outs()}, {15'd0, RST_VEC});
    nRst = 1'b1;

    do_boot(1'b0);
    do_instr(6'h05, 0, 0, 1'b0);
    do_instr(6'h0A, 0, 0, 1'b0);
    do_instr(6'h00, 0, 0, 1'b1);
    do_instr(6'h03, 2, 0, 1'b0);
    do_instr(6'h00, WL, 0, 1'b0);
    do_instr(6'h01, 0, 0, 1'b0);
    do_instr(6'h0E, 0, 0, 1'b0);
    do_instr(6'h21, 0, 0, 1'b0);
    do_instr(6'h08, 1, 1, 1'b0);
    do_instr(6'h0C, 0, 0, 1'b0);

    // Abort an instruction between DECODE and EX1.
    c_ir = 6'h08;
    emit("fetch", 1'b0, 1'b1, 5'b10100, 3'b100, 5'b0, 1'b1, 1'b0, 1'b0);
    emit("decode", 1'b0, 1'b1, 5'b10101, 3'b100, WE_IR | WE_PC, 1'b0, 1'b0, 1'b0);
    do_reset();
    do_boot(1'b1);

    rand_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        do_reset();
        do_boot(1'b1);
      end
      if ($urandom_range(0, 7) == 0) irv = IRW'($urandom_range(0, 63));
      else irv = IRW'($urandom_range(0, 15));
      do_instr(irv, rand_waits(), rand_waits(), rint());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
